// File: rtl/dircc_counter_csr_slave.sv
// Avalon-MM CSR responder for the counter test system: prescaled up/down counter
// with compare-match and wrap flags, level interrupt and a fixed-latency read pipeline.
module dircc_counter_csr_slave #(
   parameter int unsigned COUNT_WIDTH  = 32,
   parameter int unsigned READ_LATENCY = 2,
   parameter logic [31:0] BLOCK_ID     = 32'hD1CC_0001
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [2:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   output logic [31:0] avs_readdata,
   output logic        avs_readdatavalid,
   output logic        avs_waitrequest,
   output logic        irq
);

   typedef enum logic [2:0] {
      A_CTRL, A_STATUS, A_COUNT, A_LOAD, A_COMPARE, A_PRESCALE, A_ID, A_RSVD
   } addr_e;

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   logic [1:0]             r_boot;
   logic                   r_en, r_dir, r_auto, r_irq_en;
   logic                   r_match, r_wrap, r_irq;
   logic [COUNT_WIDTH-1:0] r_count, r_load, r_compare;
   logic [15:0]            r_prescale, r_presc_cnt;
   logic [READ_LATENCY-1:0] r_rd_vld;
   logic [31:0]            r_rd_data [READ_LATENCY];

   logic                   w_acc_rd, w_acc_wr;
   logic                   w_wr_ctrl, w_wr_status, w_wr_load, w_wr_cmp, w_wr_presc;
   logic                   w_clear, w_load_st, w_w1c_match, w_w1c_wrap;
   logic                   w_produced, w_set_wrap, w_set_match;
   logic [COUNT_WIDTH-1:0] w_next_count;
   logic [15:0]            w_next_presc;
   logic [31:0]            w_be_mask, w_rd_mux;

   function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [31:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   // Ready two edges after reset release; r_boot fills with ones and then saturates.
   assign avs_waitrequest   = ~r_boot[1];
   assign w_acc_rd          = avs_read  & r_boot[1];
   assign w_acc_wr          = avs_write & r_boot[1];
   assign w_be_mask         = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                               {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};

   assign w_wr_ctrl   = w_acc_wr && (avs_address == A_CTRL);
   assign w_wr_status = w_acc_wr && (avs_address == A_STATUS);
   assign w_wr_load   = w_acc_wr && (avs_address == A_LOAD);
   assign w_wr_cmp    = w_acc_wr && (avs_address == A_COMPARE);
   assign w_wr_presc  = w_acc_wr && (avs_address == A_PRESCALE);
   assign w_clear     = w_wr_ctrl   & avs_byteenable[1] & avs_writedata[8];
   assign w_load_st   = w_wr_ctrl   & avs_byteenable[1] & avs_writedata[9];
   assign w_w1c_match = w_wr_status & avs_byteenable[0] & avs_writedata[0];
   assign w_w1c_wrap  = w_wr_status & avs_byteenable[0] & avs_writedata[1];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_count = r_count;
      w_next_presc = r_presc_cnt;
      w_produced   = 1'b0;
      w_set_wrap   = 1'b0;
      if (w_clear) begin
         w_next_count = '0;
         w_next_presc = '0;
         w_produced   = 1'b1;
      end else if (w_load_st) begin
         w_next_count = r_load;
         w_next_presc = '0;
         w_produced   = 1'b1;
      end else if (!r_en) begin
         w_next_presc = '0;
      end else if (r_presc_cnt != r_prescale) begin
         w_next_presc = r_presc_cnt + 16'd1;
      end else begin
         w_next_presc = '0;
         w_produced   = 1'b1;
         if (!r_dir) begin
            if (r_count == CNT_MAX) begin
               w_set_wrap   = 1'b1;
               w_next_count = r_auto ? r_load : '0;
            end else begin
               w_next_count = r_count + COUNT_WIDTH'(1);
            end
         end else begin
            if (r_count == '0) begin
               w_set_wrap   = 1'b1;
               w_next_count = r_auto ? r_load : CNT_MAX;
            end else begin
               w_next_count = r_count - COUNT_WIDTH'(1);
            end
         end
      end
   end

   assign w_set_match = w_produced & (w_next_count == r_compare);

   always_comb begin
      w_rd_mux = '0;
      case (addr_e'(avs_address))
         A_CTRL:     w_rd_mux[3:0]  = {r_irq_en, r_auto, r_dir, r_en};
         A_STATUS:   w_rd_mux[2:0]  = {r_en, r_wrap, r_match};
         A_COUNT:    w_rd_mux       = 32'(r_count);
         A_LOAD:     w_rd_mux       = 32'(r_load);
         A_COMPARE:  w_rd_mux       = 32'(r_compare);
         A_PRESCALE: w_rd_mux[15:0] = r_prescale;
         A_ID:       w_rd_mux       = BLOCK_ID;
         default:    w_rd_mux       = '0;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_boot      <= '0;
         r_en        <= 1'b0;
         r_dir       <= 1'b0;
         r_auto      <= 1'b0;
         r_irq_en    <= 1'b0;
         r_match     <= 1'b0;
         r_wrap      <= 1'b0;
         r_irq       <= 1'b0;
         r_count     <= '0;
         r_load      <= '0;
         r_compare   <= '0;
         r_prescale  <= '0;
         r_presc_cnt <= '0;
      end else begin
         r_boot      <= {r_boot[0], 1'b1};
         r_count     <= w_next_count;
         r_presc_cnt <= w_next_presc;
         // Set beats a simultaneous write-one-to-clear.
         r_match     <= (r_match & ~w_w1c_match) | w_set_match;
         r_wrap      <= (r_wrap  & ~w_w1c_wrap)  | w_set_wrap;
         r_irq       <= r_irq_en & (r_match | r_wrap);
         if (w_wr_ctrl && avs_byteenable[0])
            {r_irq_en, r_auto, r_dir, r_en} <= avs_writedata[3:0];
         if (w_wr_load)
            r_load <= COUNT_WIDTH'(f_merge(32'(r_load), avs_writedata, w_be_mask));
         if (w_wr_cmp)
            r_compare <= COUNT_WIDTH'(f_merge(32'(r_compare), avs_writedata, w_be_mask));
         if (w_wr_presc)
            r_prescale <= 16'(f_merge(32'(r_prescale), avs_writedata, w_be_mask));
      end
   end

   // NOTE: the pipeline data is reset too (it is tiny) so readdata is exactly 0 whenever no pulse is due.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         for (int i = 0; i < int'(READ_LATENCY); i++) begin
            r_rd_vld[i]  <= 1'b0;
            r_rd_data[i] <= '0;
         end
      end else begin
         r_rd_vld[0]  <= w_acc_rd;
         r_rd_data[0] <= w_acc_rd ? w_rd_mux : '0;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            r_rd_vld[i]  <= r_rd_vld[i-1];
            r_rd_data[i] <= r_rd_data[i-1];
         end
      end
   end

   assign avs_readdatavalid = r_rd_vld[READ_LATENCY-1];
   assign avs_readdata      = r_rd_data[READ_LATENCY-1];
   assign irq               = r_irq;

endmodule
